// File: rtl/hex_display_scan_if.sv
// Signal bundle between a display controller and hex_display_scan.
// master drives value/load/enable; slave returns the registered scan outputs.
interface hex_display_scan_if #(
  parameter int NUM_DIGITS = 4
) ();
  // load is a one-cycle capture strobe, not a valid/ready handshake: the
  // scanner accepts every asserted load on that edge and never back-pressures.
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic                    enable;
  logic [3:0]              hex;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    frame_done;

  modport master (
    output value, load, enable,
    input  hex, digit_sel, frame_done
  );

  modport slave (
    input  value, load, enable,
    output hex, digit_sel, frame_done
  );
endinterface

// File: rtl/hex_display_scan.sv
// Time-multiplexed 7-segment digit scanner with frame-aligned value updates.
// Optional leading-zero blanking: define HEX_SCAN_LEADING_ZERO_BLANK_EN.
module hex_display_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  hex_display_scan_if.slave bus
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  logic [PW-1:0]         presc, presc_n;
  logic [IW-1:0]         idx, idx_n;
  logic [DW-1:0]         disp, disp_n;
  logic [DW-1:0]         pend, pend_n;
  logic                  pend_v, pend_v_n;
  logic                  tick, wrap;
  logic [NUM_DIGITS-1:0] show;

  always_comb begin
    tick     = bus.enable && (presc == PW'(DIV - 1));
    wrap     = tick && (idx == IW'(NUM_DIGITS - 1));
    presc_n  = presc;
    idx_n    = idx;
    disp_n   = disp;
    pend_n   = pend;
    pend_v_n = pend_v;
    if (bus.enable) presc_n = tick ? '0 : presc + PW'(1);
    if (tick) idx_n = wrap ? '0 : idx + IW'(1);
    // Frozen scan: nothing can tear, so a load goes straight to the display.
    if (!bus.enable) begin
      if (bus.load) begin
        disp_n   = bus.value;
        pend_v_n = 1'b0;
      end
    end else if (wrap) begin
      if (bus.load)   disp_n = bus.value;
      else if (pend_v) disp_n = pend;
      pend_v_n = 1'b0;
    end else if (bus.load) begin
      pend_n   = bus.value;
      pend_v_n = 1'b1;
    end
  end

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
  logic seen_nonzero;

  // Digit i is lit once any nibble at or above i is nonzero; digit 0 always lit.
  always_comb begin
    show         = '0;
    seen_nonzero = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      seen_nonzero = seen_nonzero | (disp_n[4*i +: 4] != 4'h0);
      show[i]      = seen_nonzero;
    end
    show[0] = 1'b1;
  end
`else
  always_comb begin
    show = '1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc          <= '0;
      idx            <= '0;
      disp           <= '0;
      pend           <= '0;
      pend_v         <= 1'b0;
      bus.hex        <= 4'h0;
      bus.digit_sel  <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      presc          <= presc_n;
      idx            <= idx_n;
      disp           <= disp_n;
      pend           <= pend_n;
      pend_v         <= pend_v_n;
      bus.hex        <= disp_n[4*idx_n +: 4];
      bus.digit_sel  <= bus.enable ? (show & (NUM_DIGITS'(1) << idx_n)) : '0;
      bus.frame_done <= wrap;
    end
  end
endmodule

// File: doc/hex_display_scan.md
# hex_display_scan

Time-multiplexed scanner for a common-segment multi-digit 7-segment display, sitting directly upstream of the `hex_to_7seg` decoder. It holds a multi-digit hex value and, on a programmable dwell interval, steps through the digits. For each digit it presents one nibble on `hex`, which feeds the decoder's `hex` input, plus a one-hot digit-select.

New values are double-buffered and applied only at frame boundaries, so a displayed number never tears mid-scan.

## Interface
- `NUM_DIGITS`, default 4: number of digits scanned; data width is 4*NUM_DIGITS.
- `DIV`, default 1000: clock cycles each digit is held (dwell); must be ≥ 2.

- `clk` in 1: clock, rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `value` in 4*NUM_DIGITS: value to display; nibble i maps to digit i, and digit 0 is the LSN.
- `load` in 1: capture `value` into the pending buffer on this edge.
- `enable` in 1: scanning active; when low, all digits are dark and the scan is frozen.
- `hex` out 4: nibble of the currently selected digit, to the decoder.
- `digit_sel` out NUM_DIGITS: one-hot, active-high digit enable; all-zero means dark.
- `frame_done` out 1: one-cycle pulse on the edge where the scan wraps back to digit 0.

## Operation
- **State:**
  - `presc`: 0..DIV-1.
  - `idx`: 0..NUM_DIGITS-1.
  - `disp`: shown value.
  - `pend` and `pend_v`: pending value and its valid flag.
- **Reset (async, `rst_n`=0):**
  - presc=0, idx=0, disp=0, pend=0, pend_v=0.
  - hex=0, digit_sel=0, frame_done=0.
- **`enable`=1:**
  - presc increments each cycle.
  - When presc=DIV-1 (tick), presc returns to 0 and idx advances.
  - idx wraps from NUM_DIGITS-1 to 0 (wrap tick).
- **`enable`=0:**
  - presc and idx hold.
  - digit_sel is driven 0.
  - When scanning resumes, the same digit is shown with its remaining dwell.
- **Load, `enable`=1:**
  - `load`=1 writes pend←value and sets pend_v=1.
  - A later load before the commit overwrites pend; last write wins.
- **Commit at wrap tick:**
  - If `load`=1 on the same edge, disp←value, bypassing pend.
  - Otherwise, if pend_v, disp←pend.
  - In both cases pend_v←0.
  - frame_done pulses on this edge whether or not a commit occurs.
- **Load, `enable`=0:** disp←value directly and pend_v←0, because no scan is in progress.
- **Output registers:**
  - hex ← disp nibble selected by the post-update idx.
  - digit_sel ← onehot(post-update idx) gated by enable and blanking.

## Timing
- All outputs are registered.
- hex and digit_sel change on the same edge that updates idx, so a new digit appears on the edge of the tick.
- After reset with `enable`=1, the first valid digit_sel (digit 0) appears 1 cycle after reset release.
- Each digit is held exactly DIV cycles, and a full frame lasts NUM_DIGITS*DIV cycles.
- Load-to-visible latency when enabled: from 1 cycle up to NUM_DIGITS*DIV cycles (the next wrap tick).
- `enable` falling: digit_sel is 0 from the next edge.
- `enable` rising: the current digit is re-shown from the next edge.
- Reset asserted mid-frame clears everything immediately, without waiting for a clock; a pending load is lost.

## Configuration
- **Macro:** `HEX_SCAN_LEADING_ZERO_BLANK_EN`.
- **Defined:**
  - Digit i (i≥1) is dark (its digit_sel bit is 0) when nibbles i..NUM_DIGITS-1 of disp are all zero.
  - Digit 0 is never blanked, so disp=0 shows a single "0".
  - Scan timing is unchanged; blanked slots still consume DIV cycles.
- **Undefined:** every digit is shown, including leading zeros.

## Test plan
All scenarios use DIV=4 and NUM_DIGITS=4.

- **Reset:** assert `rst_n`=0 mid-scan with `enable`=1 → hex=0, digit_sel=0000 and frame_done=0 immediately. After release, digit_sel=0001 and hex=0 on the first edge.
- **Basic scan:** load 0x1234 with `enable`=0, then `enable`=1 → hex sequence 4,3,2,1 with digit_sel 0001,0010,0100,1000, each held 4 cycles. frame_done pulses at the wrap.
- **Tear-free update:** while showing 0x1234, load 0xABCD while digit 1 is shown → the frame completes as 4,3,2,1, and the next frame shows D,C,B,A.
- **Boundary:** pend holds 0x5555 and `load`=1 with 0x9876 on the wrap-tick edge → the next frame shows 6,7,8,9 and pend_v=0. The following frame also shows 6,7,8,9.
- **Freeze:** drop `enable` for 10 cycles during digit 2 after 1 dwell cycle → digit_sel=0000 for those cycles. On resume, digit 2 is shown for the remaining 3 cycles, then digit 3.
- **Blanking:** load 0x0042.
  - With the macro: digit_sel shows 0001, 0010, then 0000 in the digit-2 and digit-3 slots.
  - Without the macro: hex 2,4,0,0 with all four selects active.
